unit_lane_manager: RTL

- Producer side of the unit-display interface: owns the 16 unit slots (9-bit lane location, 2-bit type) and publishes them with a gameSCEN strobe to the renderer.
- The renderer latches all locations/types on the rising edge of gameSCEN, so the published copies are held stable across that edge.
- Slots 0-7 are player units, which move right from loc 0. Slots 8-15 are enemy units, which move left from LANE_MAX.
- Accepts spawn requests through a valid/ready handshake and counts units that leak off the lane.

---
 rtl/unit_lane_manager_if.sv | 26 ++
 rtl/unit_lane_manager.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/unit_lane_manager_if.sv
// Spawn handshake plus the published unit display bus.
// The lane manager is the slave side; the spawn requester / renderer is the master.
interface unit_lane_manager_if;
    logic       spawn_valid;
    logic       spawn_side;
    logic [1:0] spawn_type;
    logic       spawn_ready;
    logic       spawn_drop;
    logic       gameSCEN;
    logic [8:0] unitLoc  [16];
    logic [1:0] unitType [16];
    logic [7:0] player_leaks;
    logic [7:0] enemy_leaks;

    modport master (
        output spawn_valid, spawn_side, spawn_type,
        input  spawn_ready, spawn_drop, gameSCEN, unitLoc, unitType,
               player_leaks, enemy_leaks
    );

    modport slave (
        input  spawn_valid, spawn_side, spawn_type,
        output spawn_ready, spawn_drop, gameSCEN, unitLoc, unitType,
               player_leaks, enemy_leaks
    );
endinterface

// File: rtl/unit_lane_manager.sv
// Unit lane manager: owns 16 unit slots, moves them once per game tick,
// and publishes a stable snapshot to the renderer behind a gameSCEN strobe.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting; accepts spawns unless a tick is pending
// UPDATE  | moves / retires one slot per cycle, idx 0..15
// COPY    | working slots copied to published outputs, strobe still low
// PUBLISH | gameSCEN high for SCEN_HIGH cycles, outputs frozen
module unit_lane_manager #(
    parameter int TICK_DIV  = 25000000,
    parameter int SPEED     = 2,
    parameter int LANE_MAX  = 420,
    parameter int SCEN_HIGH = 4
) (
    input  logic clk,
    input  logic rst,
    unit_lane_manager_if.slave bus
);
    localparam int NSLOT = 16;
    localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW    = (SCEN_HIGH > 1) ? $clog2(SCEN_HIGH) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [9:0]    SPEED10   = 10'(SPEED);
    localparam logic [9:0]    LANE10    = 10'(LANE_MAX);
    localparam logic [8:0]    SPEED9    = 9'(SPEED);
    localparam logic [8:0]    LANE9     = 9'(LANE_MAX);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_UPDATE  = 2'd1,
        S_COPY    = 2'd2,
        S_PUBLISH = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [SW-1:0]   scen_cnt_q, scen_cnt_d;
    logic [TW-1:0]   tick_cnt_q;
    logic            tick_pending_q;
    logic            tick_wrap;

    logic [8:0]      loc_q      [NSLOT];
    logic [1:0]      type_q     [NSLOT];
    logic [8:0]      pub_loc_q  [NSLOT];
    logic [1:0]      pub_type_q [NSLOT];
    logic [7:0]      pleak_q, eleak_q;

    logic            take_tick, upd_en, copy_en, spawn_ready, game_scen;
    logic            spawn_fire, spawn_ok, free_found;
    logic [3:0]      free_slot;
    logic [8:0]      cur_loc, next_loc;
    logic [1:0]      cur_type, next_type;
    logic [9:0]      adv_loc;
    logic            leak_p, leak_e;

    assign tick_wrap = (tick_cnt_q == TICK_LAST);

    // Next-state and phase decode for the tick/update/publish sequence.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        scen_cnt_d  = scen_cnt_q;
        take_tick   = 1'b0;
        upd_en      = 1'b0;
        copy_en     = 1'b0;
        spawn_ready = 1'b0;
        game_scen   = 1'b0;
        case (state_q)
            S_IDLE: begin
                spawn_ready = !tick_pending_q && !rst;
                if (tick_pending_q) begin
                    state_d   = S_UPDATE;
                    idx_d     = 4'd0;
                    take_tick = 1'b1;
                end
            end
            S_UPDATE: begin
                upd_en = 1'b1;
                idx_d  = idx_q + 4'd1;
                if (idx_q == 4'd15) state_d = S_COPY;
            end
            S_COPY: begin
                copy_en    = 1'b1;
                scen_cnt_d = SW'(SCEN_HIGH - 1);
                state_d    = S_PUBLISH;
            end
            S_PUBLISH: begin
                game_scen = 1'b1;
                if (scen_cnt_q == '0) state_d = S_IDLE;
                else                  scen_cnt_d = scen_cnt_q - SW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Lowest-index free slot on the requested side; descending scan so the lowest wins.
    always_comb begin
        free_found = 1'b0;
        free_slot  = 4'd0;
        for (int i = NSLOT / 2 - 1; i >= 0; i--) begin
            if (type_q[{bus.spawn_side, 3'(i)}] == 2'd0) begin
                free_found = 1'b1;
                free_slot  = {bus.spawn_side, 3'(i)};
            end
        end
    end

    assign spawn_fire = bus.spawn_valid && spawn_ready;
    assign spawn_ok   = spawn_fire && (bus.spawn_type != 2'd0) && free_found;

    // Movement / exit rule for the slot addressed by idx; 10-bit sum avoids 9-bit wrap.
    always_comb begin
        cur_loc   = loc_q[idx_q];
        cur_type  = type_q[idx_q];
        adv_loc   = {1'b0, cur_loc} + SPEED10;
        next_loc  = cur_loc;
        next_type = cur_type;
        leak_p    = 1'b0;
        leak_e    = 1'b0;
        if (cur_type != 2'd0) begin
            if (!idx_q[3]) begin
                if (adv_loc >= LANE10) begin
                    next_type = 2'd0;
                    next_loc  = 9'd0;
                    leak_p    = 1'b1;
                end else begin
                    next_loc = adv_loc[8:0];
                end
            end else begin
                if (cur_loc < SPEED9) begin
                    next_type = 2'd0;
                    next_loc  = 9'd0;
                    leak_e    = 1'b1;
                end else begin
                    next_loc = cur_loc - SPEED9;
                end
            end
        end
    end

    // FSM state, slot index and strobe length registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= 4'd0;
            scen_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            scen_cnt_q <= scen_cnt_d;
        end
    end

    // Free-running tick divider; a wrap while a tick is already pending is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q     <= '0;
            tick_pending_q <= 1'b0;
        end else begin
            tick_cnt_q <= tick_wrap ? '0 : tick_cnt_q + TW'(1);
            if (take_tick)      tick_pending_q <= 1'b0;
            else if (tick_wrap) tick_pending_q <= 1'b1;
        end
    end

    // Working slots: one slot per cycle in UPDATE, spawn writes only in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSLOT; i++) begin
                loc_q[i]  <= 9'd0;
                type_q[i] <= 2'd0;
            end
        end else if (upd_en) begin
            loc_q[idx_q]  <= next_loc;
            type_q[idx_q] <= next_type;
        end else if (spawn_ok) begin
            type_q[free_slot] <= bus.spawn_type;
            loc_q[free_slot]  <= bus.spawn_side ? LANE9 : 9'd0;
        end
    end

    // Published snapshot only moves in COPY, so it is stable across the strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSLOT; i++) begin
                pub_loc_q[i]  <= 9'd0;
                pub_type_q[i] <= 2'd0;
            end
        end else if (copy_en) begin
            for (int i = 0; i < NSLOT; i++) begin
                pub_loc_q[i]  <= loc_q[i];
                pub_type_q[i] <= type_q[i];
            end
        end
    end

    // Saturating leak counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            pleak_q <= 8'd0;
            eleak_q <= 8'd0;
        end else if (upd_en) begin
            if (leak_p && pleak_q != 8'hFF) pleak_q <= pleak_q + 8'd1;
            if (leak_e && eleak_q != 8'hFF) eleak_q <= eleak_q + 8'd1;
        end
    end

    assign bus.spawn_ready  = spawn_ready;
    assign bus.spawn_drop   = spawn_fire && !spawn_ok;
    assign bus.gameSCEN     = game_scen;
    assign bus.unitLoc      = pub_loc_q;
    assign bus.unitType     = pub_type_q;
    assign bus.player_leaks = pleak_q;
    assign bus.enemy_leaks  = eleak_q;
endmodule
